// File: rtl/gray_step_ctrl.sv
// -----------------------------------------------------------------------------
// gray_step_ctrl
//
// Run-length sequencer for an N-bit Gray-code counter. A start request latches
// a step count and a direction. The counter then moves one position per clock
// until that many steps have been taken. A pause level freezes the run without
// losing progress. The counter position persists between runs. Only reset or
// an explicit clear brings it back to zero.
//
// Ports:
//   clk     in   clock
//   rstn    in   synchronous active-low reset
//   start   in   run request, sampled only while idle or done
//   len     in   [N] number of steps, latched on an accepted start
//   dir     in   0 = count up, 1 = count down, latched on an accepted start
//   pause   in   level; while high during a run, no step is taken
//   clr     in   zero the counter while idle or done and start is low
//   busy    out  run in progress (RUN or HOLD)
//   paused  out  run is currently held by pause (HOLD)
//   done    out  one-cycle completion pulse (DONE)
//   bin     out  [N] registered binary position
//   gray    out  [N] registered Gray code of bin
// -----------------------------------------------------------------------------
module gray_step_ctrl #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         start,
    input  logic [N-1:0] len,
    input  logic         dir,
    input  logic         pause,
    input  logic         clr,
    output logic         busy,
    output logic         paused,
    output logic         done,
    output logic [N-1:0] bin,
    output logic [N-1:0] gray
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

    state_t       state_q, state_d;
    logic [N-1:0] bin_q,   bin_d;
    logic [N-1:0] gray_q,  gray_d;
    logic [N-1:0] rem_q,   rem_d;
    logic         dir_q,   dir_d;

    function automatic logic [N-1:0] bin2gray(input logic [N-1:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [N-1:0] step_pos(input logic [N-1:0] b,
                                              input logic         down);
        // Modular wrap in both directions comes for free from the N-bit width.
        return down ? (b - ONE) : (b + ONE);
    endfunction

    // Next-state and next-datapath decode
    always_comb begin
        state_d = state_q;
        bin_d   = bin_q;
        gray_d  = gray_q;
        rem_d   = rem_q;
        dir_d   = dir_q;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    // start wins over clr. A zero-length run goes straight to
                    // DONE so the caller still sees a completion pulse.
                    rem_d   = len;
                    dir_d   = dir;
                    state_d = (len != '0) ? RUN : DONE;
                end else begin
                    state_d = IDLE;
                    if (clr) begin
                        bin_d  = '0;
                        gray_d = '0;
                    end
                end
            end

            RUN, HOLD: begin
                if (pause) begin
                    state_d = HOLD;
                end else begin
                    bin_d   = step_pos(bin_q, dir_q);
                    gray_d  = bin2gray(bin_d);
                    rem_d   = rem_q - ONE;
                    // rem counts steps still owed including this one, so the
                    // last step is the one taken while rem is 1.
                    state_d = (rem_q == ONE) ? DONE : RUN;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= IDLE;
            bin_q   <= '0;
            gray_q  <= '0;
            rem_q   <= '0;
            dir_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            bin_q   <= bin_d;
            gray_q  <= gray_d;
            rem_q   <= rem_d;
            dir_q   <= dir_d;
        end
    end

    // Status decoded from registered state only
    assign busy   = (state_q == RUN) || (state_q == HOLD);
    assign paused = (state_q == HOLD);
    assign done   = (state_q == DONE);
    assign bin    = bin_q;
    assign gray   = gray_q;

endmodule

// File: tb/tb_gray_step_ctrl.sv
module tb_gray_step_ctrl;

    localparam int N   = 4;
    localparam int MOD = 2 ** N;

    logic         clk   = 1'b0;
    logic         rstn  = 1'b0;
    logic         start = 1'b0;
    logic [N-1:0] len   = '0;
    logic         dir   = 1'b0;
    logic         pause = 1'b0;
    logic         clr   = 1'b0;
    logic         busy, paused, done;
    logic [N-1:0] bin, gray;

    always #5 clk = ~clk;

    gray_step_ctrl #(.N(N)) dut (
        .clk(clk), .rstn(rstn), .start(start), .len(len), .dir(dir),
        .pause(pause), .clr(clr), .busy(busy), .paused(paused), .done(done),
        .bin(bin), .gray(gray)
    );

    int nvec  = 0;
    int nfail = 0;

    // Reference model: position as an integer, steps still owed, flags.
    int m_pos  = 0;
    int m_left = 0;
    bit m_up   = 1'b1;
    bit m_done = 1'b0;
    bit m_held = 1'b0;
    bit m_step = 1'b0;
    bit m_zero = 1'b0;
    logic [N-1:0] prev_gray;

    typedef struct {
        logic r, s;
        logic [N-1:0] l;
        logic d, p, c;
        logic [N-1:0] eb, eg;
        logic ebusy, epaused, edone;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic r, s, input logic [N-1:0] l,
                                input logic d, p, c,
                                input logic [N-1:0] eb, eg,
                                input logic ebusy, epaused, edone);
        vec_t v;
        v.r = r; v.s = s; v.l = l; v.d = d; v.p = p; v.c = c;
        v.eb = eb; v.eg = eg; v.ebusy = ebusy; v.epaused = epaused; v.edone = edone;
        return v;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        nvec++;
        if (act != exp) begin
            nfail++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    task automatic model_edge(input logic r, s, input logic [N-1:0] l,
                              input logic d, p, c);
        m_step = 1'b0;
        m_zero = 1'b0;
        if (!r) begin
            m_pos = 0; m_left = 0; m_up = 1'b1; m_done = 1'b0; m_held = 1'b0;
            m_zero = 1'b1;
        end else if (m_left > 0) begin
            m_done = 1'b0;
            if (p) begin
                m_held = 1'b1;
            end else begin
                m_held = 1'b0;
                m_pos  = m_up ? (m_pos + 1) % MOD : (m_pos + MOD - 1) % MOD;
                m_left = m_left - 1;
                m_step = 1'b1;
                m_done = (m_left == 0);
            end
        end else begin
            m_held = 1'b0;
            if (s) begin
                m_left = int'(l);
                m_up   = !d;
                m_done = (l == 0);
            end else begin
                m_done = 1'b0;
                if (c) begin
                    m_pos  = 0;
                    m_zero = 1'b1;
                end
            end
        end
    endtask

    // One clock: drive inputs on the falling edge, update the model at the
    // rising edge, then check the structural gray properties.
    task automatic cycle(input logic r, s, input logic [N-1:0] l,
                         input logic d, p, c);
        @(negedge clk);
        rstn = r; start = s; len = l; dir = d; pause = p; clr = c;
        prev_gray = gray;
        @(posedge clk);
        model_edge(r, s, l, d, p, c);
        #1;
        check("gray_code", int'(gray), int'(bin ^ (bin >> 1)));
        if (m_step)
            check("gray_one_bit", $countones(gray ^ prev_gray), 1);
        else if (!m_zero)
            check("gray_hold", int'(gray), int'(prev_gray));
    endtask

    task automatic check_model();
        check("bin",    int'(bin),    m_pos);
        check("gray",   int'(gray),   m_pos ^ (m_pos >> 1));
        check("busy",   int'(busy),   int'(m_left > 0));
        check("paused", int'(paused), int'(m_held));
        check("done",   int'(done),   int'(m_done));
    endtask

    initial begin
        bit seen;

        // r s len d p c | bin gray busy paused done
        // reset, basic up run of 5
        tbl.push_back(mk(0,0,0,0,0,0,  0, 0,0,0,0));
        tbl.push_back(mk(1,1,5,0,0,0,  0, 0,1,0,0));
        tbl.push_back(mk(1,0,0,0,0,0,  1, 1,1,0,0));
        tbl.push_back(mk(1,0,0,0,0,0,  2, 3,1,0,0));
        tbl.push_back(mk(1,0,0,0,0,0,  3, 2,1,0,0));
        tbl.push_back(mk(1,0,0,0,0,0,  4, 6,1,0,0));
        tbl.push_back(mk(1,0,0,0,0,0,  5, 7,0,0,1));
        tbl.push_back(mk(1,0,0,0,0,0,  5, 7,0,0,0));
        // clear, then down wrap of 3
        tbl.push_back(mk(1,0,0,0,0,1,  0, 0,0,0,0));
        tbl.push_back(mk(1,1,3,1,0,0,  0, 0,1,0,0));
        tbl.push_back(mk(1,0,0,0,0,0, 15, 8,1,0,0));
        tbl.push_back(mk(1,0,0,0,0,0, 14, 9,1,0,0));
        tbl.push_back(mk(1,0,0,0,0,0, 13,11,0,0,1));
        tbl.push_back(mk(1,0,0,0,0,0, 13,11,0,0,0));
        // clear, run of 4 with two paused cycles after the 2nd step
        tbl.push_back(mk(1,0,0,0,0,1,  0, 0,0,0,0));
        tbl.push_back(mk(1,1,4,0,0,0,  0, 0,1,0,0));
        tbl.push_back(mk(1,0,0,0,0,0,  1, 1,1,0,0));
        tbl.push_back(mk(1,0,0,0,0,0,  2, 3,1,0,0));
        tbl.push_back(mk(1,0,0,0,1,0,  2, 3,1,1,0));
        tbl.push_back(mk(1,0,0,0,1,0,  2, 3,1,1,0));
        tbl.push_back(mk(1,0,0,0,0,0,  3, 2,1,0,0));
        tbl.push_back(mk(1,0,0,0,0,0,  4, 6,0,0,1));
        // zero-length start in DONE, then len=2 back-to-back in DONE
        tbl.push_back(mk(1,1,0,0,0,0,  4, 6,0,0,1));
        tbl.push_back(mk(1,1,2,0,0,0,  4, 6,1,0,0));
        tbl.push_back(mk(1,0,0,0,0,0,  5, 7,1,0,0));
        tbl.push_back(mk(1,0,0,0,0,0,  6, 5,0,0,1));
        // run of 3; start/len=9/clr during the run are ignored
        tbl.push_back(mk(1,1,3,0,0,0,  6, 5,1,0,0));
        tbl.push_back(mk(1,1,9,1,0,1,  7, 4,1,0,0));
        tbl.push_back(mk(1,0,0,0,0,0,  8,12,1,0,0));
        tbl.push_back(mk(1,0,0,0,0,0,  9,13,0,0,1));
        tbl.push_back(mk(1,0,0,0,0,1,  0, 0,0,0,0));
        // reset in the middle of a run of 8 at bin=6
        tbl.push_back(mk(1,1,8,0,0,0,  0, 0,1,0,0));
        tbl.push_back(mk(1,0,0,0,0,0,  1, 1,1,0,0));
        tbl.push_back(mk(1,0,0,0,0,0,  2, 3,1,0,0));
        tbl.push_back(mk(1,0,0,0,0,0,  3, 2,1,0,0));
        tbl.push_back(mk(1,0,0,0,0,0,  4, 6,1,0,0));
        tbl.push_back(mk(1,0,0,0,0,0,  5, 7,1,0,0));
        tbl.push_back(mk(1,0,0,0,0,0,  6, 5,1,0,0));
        tbl.push_back(mk(0,0,0,0,0,0,  0, 0,0,0,0));
        tbl.push_back(mk(1,0,0,0,0,0,  0, 0,0,0,0));

        foreach (tbl[i]) begin
            cycle(tbl[i].r, tbl[i].s, tbl[i].l, tbl[i].d, tbl[i].p, tbl[i].c);
            check($sformatf("tbl%0d_bin", i),    int'(bin),    int'(tbl[i].eb));
            check($sformatf("tbl%0d_gray", i),   int'(gray),   int'(tbl[i].eg));
            check($sformatf("tbl%0d_busy", i),   int'(busy),   int'(tbl[i].ebusy));
            check($sformatf("tbl%0d_paused", i), int'(paused), int'(tbl[i].epaused));
            check($sformatf("tbl%0d_done", i),   int'(done),   int'(tbl[i].edone));
        end

        // Full-length run of 2^N-1 steps ends one short of the start point,
        // then a single up step wraps 15 -> 0 (gray 1000 -> 0000).
        cycle(0, 0, 0, 0, 0, 0);
        cycle(1, 1, 4'd15, 0, 0, 0);
        check_model();
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            cycle(1, 0, 0, 0, 0, 0);
            check_model();
            if (done) seen = 1'b1;
        end
        check("full_run_done_seen", int'(seen), 1);
        check("full_run_bin", int'(bin), 15);
        check("full_run_gray", int'(gray), 8);
        cycle(1, 1, 4'd1, 0, 0, 0);
        check("wrap_busy", int'(busy), 1);
        cycle(1, 0, 0, 0, 0, 0);
        check("wrap_bin", int'(bin), 0);
        check("wrap_gray", int'(gray), 0);
        check("wrap_done", int'(done), 1);
        check_model();

        // Randomized traffic against the reference model.
        for (int i = 0; i < 3000; i++) begin
            logic r, s, d, p, c;
            logic [N-1:0] l;
            r = ($urandom_range(0, 199) != 0);
            s = ($urandom_range(0, 3) == 0);
            l = ($urandom_range(0, 3) == 0) ? N'($urandom_range(0, MOD - 1))
                                            : N'($urandom_range(0, 5));
            d = N'($urandom_range(0, 1)) != 0;
            p = ($urandom_range(0, 3) == 0);
            c = ($urandom_range(0, 7) == 0);
            cycle(r, s, l, d, p, c);
            check_model();
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
